// File: rtl/tl_sensor_cond.sv
// Sensor conditioning for the left-turn traffic-light controller: per-lane sync, debounce, hold.
// Optional per-lane arrival counters are enabled by defining TL_CAR_CNT_EN.
module tl_sensor_cond #(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned HOLD_CYC = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sa_raw,
  input  logic       sal_raw,
  input  logic       sb_raw,
  input  logic       sbl_raw,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl
`ifdef TL_CAR_CNT_EN
  ,
  input  logic       cnt_clr,
  output logic [7:0] car_cnt_a,
  output logic [7:0] car_cnt_al,
  output logic [7:0] car_cnt_b,
  output logic [7:0] car_cnt_bl
`endif
);

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYC - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC);

  logic [3:0] raw;
  logic [3:0] t;

  assign raw = {sbl_raw, sb_raw, sal_raw, sa_raw};

`ifdef TL_CAR_CNT_EN
  logic [3:0][7:0] car_cnt;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic       s1;
    logic       s2;
    logic       deb;
    logic       deb_nx;
    logic       t_q;
    logic [7:0] dcnt;
    logic [7:0] dcnt_nx;
    logic [7:0] hcnt;
    logic [7:0] hcnt_nx;

    always_comb begin
      deb_nx  = deb;
      dcnt_nx = dcnt + 8'd1;
      if (s2 == deb) begin
        dcnt_nx = '0;
      end else if (dcnt == DEB_LAST) begin
        deb_nx  = s2;
        dcnt_nx = '0;
      end

      hcnt_nx = hcnt;
      if (deb && !deb_nx) begin
        hcnt_nx = HOLD_LOAD;
      end else if (!deb && deb_nx) begin
        hcnt_nx = '0;
      end else if (hcnt != '0) begin
        hcnt_nx = hcnt - 8'd1;
      end
    end

    // Output is computed from next-state values so it changes on the same edge as deb/hcnt.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        deb  <= 1'b0;
        dcnt <= '0;
        hcnt <= '0;
        t_q  <= 1'b0;
      end else begin
        s1   <= raw[g];
        s2   <= s1;
        deb  <= deb_nx;
        dcnt <= dcnt_nx;
        hcnt <= hcnt_nx;
        t_q  <= deb_nx | (hcnt_nx != '0);
      end
    end

    assign t[g] = t_q;

`ifdef TL_CAR_CNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (cnt_clr) begin
        cnt <= '0;
      end else if (!deb && deb_nx && (cnt != '1)) begin
        cnt <= cnt + 8'd1;
      end
    end

    assign car_cnt[g] = cnt;
`endif
  end

  assign Ta  = t[0];
  assign Tal = t[1];
  assign Tb  = t[2];
  assign Tbl = t[3];

`ifdef TL_CAR_CNT_EN
  assign car_cnt_a  = car_cnt[0];
  assign car_cnt_al = car_cnt[1];
  assign car_cnt_b  = car_cnt[2];
  assign car_cnt_bl = car_cnt[3];
`endif

endmodule
